// File: rtl/hs_fifo_lvl.sv
// Valid/ready FIFO with arbitrary depth, occupancy level, almost flags and flush.
// Define HS_FIFO_LVL_OUT_REG_EN for a registered output stage (capacity +1).
module hs_fifo_lvl #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  data_in_vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_in_rdy,
  output logic                  data_out_vld,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_out_rdy,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic                  w_ph, r_ph;
  logic                  ram_full, ram_empty;
  logic                  wr, rd, ram_rd;

  function automatic logic [ADDR_WIDTH:0] bump(
    input logic                  ph,
    input logic [ADDR_WIDTH-1:0] p
  );
    if (p == LAST) return {~ph, {ADDR_WIDTH{1'b0}}};
    else           return {ph, p + 1'b1};
  endfunction

  assign ram_full  = (w_ptr == r_ptr) & (w_ph != r_ph);
  assign ram_empty = (w_ptr == r_ptr) & (w_ph == r_ph);

  assign data_in_rdy = ~ram_full;
  assign wr          = data_in_vld & ~ram_full;

`ifdef HS_FIFO_LVL_OUT_REG_EN
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] out_q;

  assign rd     = out_vld & data_out_rdy;
  // refill the output register when it is empty or draining this cycle
  assign ram_rd = ~ram_empty & (~out_vld | data_out_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (ram_rd) begin
      out_vld <= 1'b1;
      out_q   <= mem[r_ptr];
    end else if (rd) begin
      out_vld <= 1'b0;
    end
  end

  assign data_out_vld = out_vld;
  assign data_out     = out_q;
`else
  assign rd           = ~ram_empty & data_out_rdy;
  assign ram_rd       = rd;
  assign data_out_vld = ~ram_empty;
  assign data_out     = mem[r_ptr];
`endif

  always_ff @(posedge clk) begin
    if (wr & ~flush) mem[w_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      w_ph  <= 1'b0;
      r_ph  <= 1'b0;
      level <= '0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      w_ph  <= 1'b0;
      r_ph  <= 1'b0;
      level <= '0;
    end else begin
      if (wr)     {w_ph, w_ptr} <= bump(w_ph, w_ptr);
      if (ram_rd) {r_ph, r_ptr} <= bump(r_ph, r_ptr);
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign almost_full  = level >= LW'(AF_THRESH);
  assign almost_empty = level <= LW'(AE_THRESH);

endmodule
